// File: rtl/stage2_pool_if.sv
// Stream bundle between the stage-2 adder, stage2_pool and the S4 consumer.
// The master drives the raster samples and bias; the slave returns pooled results.
interface stage2_pool_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                         en;
   logic signed [DATA_WIDTH-1:0] datain;
   logic signed [DATA_WIDTH-1:0] bias;
   logic signed [DATA_WIDTH-1:0] dataout;
   logic                         out_valid;
   logic                         frame_done;

   modport master (
      output en, datain, bias,
      input  dataout, out_valid, frame_done
   );

   modport slave (
      input  en, datain, bias,
      output dataout, out_valid, frame_done
   );
endinterface

// File: rtl/stage2_pool.sv
// Bias add, saturate-or-wrap, ReLU, then 2x2 stride-2 max pooling over a raster stream.
// Macro STAGE2_POOL_SAT_EN: when defined the bias sum saturates, otherwise it wraps.
module stage2_pool #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_W      = 10,
   parameter int IMG_H      = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   stage2_pool_if.slave bus
);
   localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int HALF_W = IMG_W / 2;
   localparam int HW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

   function automatic sample_t reduce_sum(input logic signed [DATA_WIDTH:0] s);
`ifdef STAGE2_POOL_SAT_EN
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
         return s[DATA_WIDTH] ? sample_t'({1'b1, {(DATA_WIDTH-1){1'b0}}})
                              : sample_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
      return s[DATA_WIDTH-1:0];
`else
      return s[DATA_WIDTH-1:0];
`endif
   endfunction

   function automatic sample_t relu(input sample_t x);
      return x[DATA_WIDTH-1] ? '0 : x;
   endfunction

   function automatic sample_t smax(input sample_t a, input sample_t b);
      return (a > b) ? a : b;
   endfunction

   // input capture
   logic                         in_vld_q;
   sample_t                      din_q;
   sample_t                      bias_q;
   // activation
   logic                         act_vld_q;
   sample_t                      act_q;
   logic signed [DATA_WIDTH:0]   sum_d;
   sample_t                      act_d;
   // pooling
   logic [CW-1:0]                col_q, col_d;
   logic [RW-1:0]                row_q, row_d;
   logic [HW-1:0]                half_idx;
   sample_t                      hreg_q;
   sample_t                      rowbuf_q [HALF_W];
   sample_t                      hmax_d;
   sample_t                      pool_d;
   sample_t                      dataout_q;
   logic                         out_valid_q;
   logic                         frame_done_q;
   logic                         win_done;

   always_comb begin
      sum_d    = {din_q[DATA_WIDTH-1], din_q} + {bias_q[DATA_WIDTH-1], bias_q};
      act_d    = relu(reduce_sum(sum_d));
      half_idx = HW'(col_q >> 1);
      hmax_d   = smax(hreg_q, act_q);
      pool_d   = smax(rowbuf_q[half_idx], hmax_d);
      win_done = act_vld_q & col_q[0] & row_q[0];
      col_d    = col_q;
      row_d    = row_q;
      if (act_vld_q) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Datapath registers carry no reset; the valid chain qualifies every use.
   always_ff @(posedge clk) begin
      if (bus.en) begin
         din_q  <= bus.datain;
         bias_q <= bus.bias;
      end
      if (in_vld_q)
         act_q <= act_d;
      if (act_vld_q && !col_q[0])
         hreg_q <= act_q;
      if (act_vld_q && col_q[0] && !row_q[0])
         rowbuf_q[half_idx] <= hmax_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_vld_q     <= 1'b0;
         act_vld_q    <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         dataout_q    <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         in_vld_q     <= bus.en;
         act_vld_q    <= in_vld_q;
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= win_done;
         frame_done_q <= win_done && (col_q == COL_LAST) && (row_q == ROW_LAST);
         if (win_done)
            dataout_q <= pool_d;
      end
   end

   assign bus.dataout    = dataout_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_stage2_pool.sv
// Randomised directed bench for stage2_pool against a whole-frame pooling model.
module tb_stage2_pool;
   localparam int DW = 16;
   localparam int W  = 10;
   localparam int H  = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stage2_pool_if #(.DATA_WIDTH(DW)) bus ();

   stage2_pool #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   int got_v[$];
   int got_fd[$];
   int got_cyc[$];
   int orphan_fd = 0;
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         got_v.push_back(int'(bus.dataout));
         got_fd.push_back(bus.frame_done === 1'b1 ? 1 : 0);
         got_cyc.push_back(cyc);
      end else if (bus.frame_done !== 1'b0) begin
         orphan_fd <= orphan_fd + 1;
      end
   end

   int checks = 0;
   int fails  = 0;
   int pix [H][W];
   int bia;
   int t11;
   int exp_v[$];
   int exp_fd[$];

   task automatic check(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   // Reference: bias add in wide integer arithmetic, clamp or wrap, ReLU.
   function automatic int act_of(input int d, input int b);
      int s;
      s = d + b;
`ifdef STAGE2_POOL_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`else
      s = s & 32'h0000_FFFF;
      if (s >= 32768) s = s - 65536;
`endif
      return (s < 0) ? 0 : s;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic push_expect();
      for (int i = 0; i < H / 2; i++)
         for (int j = 0; j < W / 2; j++) begin
            exp_v.push_back(max4(act_of(pix[2*i][2*j], bia),   act_of(pix[2*i][2*j+1], bia),
                                 act_of(pix[2*i+1][2*j], bia), act_of(pix[2*i+1][2*j+1], bia)));
            exp_fd.push_back((i == H / 2 - 1 && j == W / 2 - 1) ? 1 : 0);
         end
   endtask

   task automatic clear_expect();
      exp_v.delete();
      exp_fd.delete();
   endtask

   task automatic ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            pix[r][c] = r * 10 + c;
   endtask

   task automatic idle(input int n);
      bus.en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nsamp raster samples of pix, preceding each with gmin..gmax idle cycles.
   task automatic drive(input int nsamp, input int gmin, input int gmax);
      int k;
      k = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (k < nsamp) begin
               if (gmax > 0) idle($urandom_range(gmin, gmax));
               if (r == 1 && c == 1) t11 = cyc + 1;
               bus.en     = 1'b1;
               bus.datain = DW'(pix[r][c]);
               bus.bias   = DW'(bia);
               @(negedge clk);
            end
            k++;
         end
      bus.en = 1'b0;
   endtask

   task automatic compare(input string tag, input int base);
      int n;
      idle(6);
      n = got_v.size() - base;
      check({tag, "_count"}, n, exp_v.size());
      for (int k = 0; k < exp_v.size(); k++)
         if (base + k < got_v.size()) begin
            check($sformatf("%s_val%0d", tag, k), got_v[base+k], exp_v[k]);
            check($sformatf("%s_fd%0d", tag, k), got_fd[base+k], exp_fd[k]);
         end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_dataout"}, int'(bus.dataout), 0);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_frame_done"}, int'(bus.frame_done), 0);
   endtask

   initial begin
      int base;
      int b0;
      int nfd;
      bus.en = 1'b0;
      bus.datain = '0;
      bus.bias = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // continuous ramp, bias 0
      ramp(); bia = 0;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      compare("ramp", base);
      check("ramp_first", got_v[base], 11);
      check("ramp_last", got_v[base+24], 99);
      check("ramp_latency", got_cyc[base], t11 + 2);

      // negative biases
      bia = -100;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      compare("bias_m100", base);
      check("bias_m100_last", got_v[base+24], 0);

      bia = -50;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      compare("bias_m50", base);

      // overflow of the bias sum
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            pix[r][c] = 32767;
      bia = 5;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      compare("ovf", base);
`ifdef STAGE2_POOL_SAT_EN
      check("ovf_value", got_v[base], 32767);
`else
      check("ovf_value", got_v[base], 0);
`endif

      // ramp with random gaps before every sample
      ramp(); bia = 0;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 1, 5);
      compare("gaps", base);

      // reset mid-frame, then a clean ramp frame
      drive(37, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("midreset");
      rst_n = 1'b1;
      b0 = got_v.size();
      idle(4);
      check("midreset_quiet", got_v.size(), b0);
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      compare("after_reset", base);

      // two frames back to back
      clear_expect(); push_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 0);
      drive(W * H, 0, 0);
      compare("two_frames", base);
      nfd = 0;
      for (int k = base; k < got_fd.size(); k++) nfd += got_fd[k];
      check("two_frames_fd_count", nfd, 2);

      // random full-range data with random bias and sparse gaps
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               pix[r][c] = int'($signed(16'($urandom)));
         bia = int'($signed(16'($urandom)));
         clear_expect(); push_expect();
         base = got_v.size();
         drive(W * H, 0, 2);
         compare($sformatf("rand_full%0d", f), base);
      end

      // small-magnitude data so ties and mixed signs are frequent
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            pix[r][c] = $urandom_range(0, 40) - 20;
      bia = $urandom_range(0, 10) - 5;
      clear_expect(); push_expect();
      base = got_v.size();
      drive(W * H, 0, 3);
      compare("rand_small", base);

      check("orphan_frame_done", orphan_fd, 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
